// File: rtl/emoji_sound_scheduler.sv
// Emoji clip scheduler: request FIFO, sample-rate tick and a clip
// sequencer that shares one ROM port with the codec sample path.
module emoji_sound_scheduler #(
  parameter int DIV       = 1134,
  parameter int CLIP_LEN  = 4096,
  parameter int GAP_TICKS = 441,
  parameter int QDEPTH    = 4
) (
  input  logic        FPGA_clock,
  input  logic        reset,
  input  logic        char_valid,
  input  logic [7:0]  ascii_code,
  input  logic [15:0] rom_q,
  output logic [11:0] rom_address,
  output logic [1:0]  rom_select,
  output logic        rom_en,
  output logic [15:0] audio_out,
  output logic        sample_strobe,
  output logic        busy,
  output logic        queue_full,
  output logic        dropped
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  localparam logic [TW-1:0] TMAX  = TW'(DIV - 1);
  localparam logic [11:0]   AMAX  = 12'(CLIP_LEN - 1);
  localparam logic [GW-1:0] GMAX  = GW'(GAP_TICKS - 1);
  localparam logic [AW:0]   QFULL = (AW + 1)'(QDEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    PLAY,
    GAP
  } state_t;

  state_t        state_q;

  logic [TW-1:0] tcnt_q;
  logic [TW-1:0] tcnt_d;
  logic          tick;

  logic [1:0]    mem_q [QDEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic          is_emoji;
  logic          full;
  logic          pop;
  logic          push;
  logic          dropped_q;

  logic [11:0]   addr_q;
  logic          done_q;
  logic          issue;
  logic          rd_v_q;
  logic          rd_last_q;
  logic [GW-1:0] gap_q;
  logic [11:0]   rom_address_q;
  logic [1:0]    sel_q;
  logic          rom_en_q;
  logic [15:0]   audio_q;
  logic          strobe_q;

  // Tick, FIFO control and read-issue decisions
  always_comb begin
    tick     = (tcnt_q == TMAX);
    tcnt_d   = tick ? '0 : tcnt_q + 1'b1;
    is_emoji = char_valid && (ascii_code[7:2] == 6'b100000);
    full     = (cnt_q == QFULL);
    pop      = (state_q == IDLE) && (cnt_q != '0);
    // A full FIFO still accepts a push when its head leaves this cycle
    push     = is_emoji && (!full || pop);
    cnt_d    = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
    // The START tick issues address 0; the pulse itself lands in PLAY
    issue = tick &&
            ((state_q == START) ||
             ((state_q == PLAY) && !done_q));
  end

  // Free-running sample-rate divider
  always_ff @(posedge FPGA_clock or posedge reset) begin
    if (reset) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  // Request FIFO storage, pointers and drop flag
  always_ff @(posedge FPGA_clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      dropped_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= ascii_code[1:0];
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      cnt_q     <= cnt_d;
      dropped_q <= is_emoji && !push;
    end
  end

  // Clip sequencer with registered ROM and codec outputs
  always_ff @(posedge FPGA_clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      addr_q        <= '0;
      done_q        <= 1'b0;
      rom_address_q <= '0;
      rom_en_q      <= 1'b0;
      rd_v_q        <= 1'b0;
      rd_last_q     <= 1'b0;
      gap_q         <= '0;
      audio_q       <= '0;
      strobe_q      <= 1'b0;
    end else begin
      rom_en_q  <= issue;
      strobe_q  <= 1'b0;
      // rom_q is valid in the cycle after rom_en; latch it then
      rd_v_q    <= rom_en_q;
      rd_last_q <= rom_en_q && (rom_address_q == AMAX);
      if (issue) begin
        rom_address_q <= addr_q;
        if (addr_q == AMAX) begin
          done_q <= 1'b1;
        end else begin
          addr_q <= addr_q + 1'b1;
        end
      end
      unique case (state_q)
        IDLE: begin
          audio_q <= '0;
          if (pop) begin
            sel_q   <= mem_q[rptr_q];
            addr_q  <= '0;
            done_q  <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (tick) begin
            state_q <= PLAY;
          end
        end
        PLAY: begin
          if (rd_v_q) begin
            audio_q  <= rom_q;
            strobe_q <= 1'b1;
            if (rd_last_q) begin
              state_q <= GAP;
              gap_q   <= '0;
            end
          end
        end
        GAP: begin
          audio_q <= '0;
          if (tick) begin
            if (gap_q == GMAX) begin
              state_q <= IDLE;
            end else begin
              gap_q <= gap_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_address   = rom_address_q;
  assign rom_select    = sel_q;
  assign rom_en        = rom_en_q;
  assign audio_out     = audio_q;
  assign sample_strobe = strobe_q;
  assign busy          = (state_q != IDLE);
  assign queue_full    = full;
  assign dropped       = dropped_q;

endmodule

// File: tb/tb_emoji_sound_scheduler.sv
// Bench for emoji_sound_scheduler: request-level reference schedule
// feeding scoreboards that a negedge monitor drains.
module tb_emoji_sound_scheduler;

  localparam int DIV = 4;
  localparam int CL  = 8;
  localparam int GT  = 2;
  localparam int QD  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cv = 1'b0;
  logic [7:0]  code = '0;
  logic [15:0] rom_q = '0;
  logic [11:0] rom_address;
  logic [1:0]  rom_select;
  logic        rom_en;
  logic [15:0] audio_out;
  logic        sample_strobe;
  logic        busy;
  logic        queue_full;
  logic        dropped;

  always #5 clk = ~clk;

  emoji_sound_scheduler #(
    .DIV(DIV), .CLIP_LEN(CL), .GAP_TICKS(GT), .QDEPTH(QD)
  ) dut (
    .FPGA_clock   (clk),
    .reset        (rst),
    .char_valid   (cv),
    .ascii_code   (code),
    .rom_q        (rom_q),
    .rom_address  (rom_address),
    .rom_select   (rom_select),
    .rom_en       (rom_en),
    .audio_out    (audio_out),
    .sample_strobe(sample_strobe),
    .busy         (busy),
    .queue_full   (queue_full),
    .dropped      (dropped)
  );

  function automatic logic [15:0] rom_fn(
    input logic [1:0] s, input logic [11:0] a);
    return {s, a, 2'b11} ^ 16'h0F0F;
  endfunction

  // Synchronous clip ROM: data one cycle after the strobe
  always @(posedge clk) begin
    if (rom_en) rom_q <= rom_fn(rom_select, rom_address);
  end

  typedef struct {
    int         e;
    logic [1:0] s;
    logic [11:0] a;
  } rd_t;

  typedef struct {
    int          e;
    logic [15:0] v;
  } smp_t;

  rd_t        xr[$];
  smp_t       xs[$];
  int         xz[$];
  int         xd[$];
  logic [1:0] mq[$];
  int         ecnt;
  bit         m_idle;
  int         m_g;
  bit         m_busy;
  bit         m_full;
  bit         m_pop;
  int         e1, cl_end, g1;
  logic [1:0] m_s;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at edge %0d",
                  nm, act, exp, ecnt);
  endtask

  // Reference: edges counted from reset release; a tick ends on
  // every edge that is a multiple of DIV. A popped clip reads one
  // address per tick from the first tick after the pop, samples
  // appear two edges after each read, then GT silent ticks follow.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete(); xr.delete(); xs.delete();
      xz.delete(); xd.delete();
      ecnt = 0; m_idle = 1; m_g = 0;
      m_busy = 0; m_full = 0;
    end else begin
      ecnt++;
      m_pop = m_idle && (mq.size() > 0);
      if (cv && code[7:2] == 6'b100000) begin
        if (mq.size() < QD || m_pop) mq.push_back(code[1:0]);
        else xd.push_back(ecnt);
      end
      if (m_pop) begin
        m_s = mq.pop_front();
        m_idle = 0;
        e1 = (ecnt / DIV + 1) * DIV;
        for (int k = 0; k < CL; k++) begin
          xr.push_back('{e1 + k * DIV, m_s, 12'(k)});
          xs.push_back('{e1 + k * DIV + 2, rom_fn(m_s, 12'(k))});
        end
        cl_end = e1 + (CL - 1) * DIV + 2;
        xz.push_back(cl_end + 1);
        g1 = (cl_end / DIV + 1) * DIV;
        m_g = g1 + (GT - 1) * DIV;
      end else if (!m_idle && ecnt == m_g) begin
        m_idle = 1;
      end
      m_busy = !m_idle;
      m_full = (mq.size() == QD);
    end
  end

  rd_t         mr;
  smp_t        ms;
  logic [15:0] m_aud = '0;

  // Monitor: pop and compare on every DUT output event
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs",
          {rom_en, sample_strobe, busy, queue_full, dropped,
           audio_out, rom_address, rom_select}, 0);
      m_aud = '0;
    end else begin
      if (rom_en) begin
        if (xr.size() == 0) chk("rom_en_unexpected", 1, 0);
        else begin
          mr = xr.pop_front();
          chk("rom_en_edge", ecnt, mr.e);
          chk("rom_address", rom_address, mr.a);
          chk("rom_select", rom_select, mr.s);
        end
      end else if (xr.size() > 0 && xr[0].e <= ecnt) begin
        chk("rom_en_missing", 0, 1);
        void'(xr.pop_front());
      end
      if (sample_strobe) begin
        if (xs.size() == 0) chk("strobe_unexpected", 1, 0);
        else begin
          ms = xs.pop_front();
          chk("strobe_edge", ecnt, ms.e);
          m_aud = ms.v;
        end
      end else if (xs.size() > 0 && xs[0].e <= ecnt) begin
        chk("strobe_missing", 0, 1);
        m_aud = xs.pop_front().v;
      end
      if (xz.size() > 0 && xz[0] <= ecnt) begin
        m_aud = '0;
        void'(xz.pop_front());
      end
      chk("audio_out", audio_out, m_aud);
      if (dropped) begin
        if (xd.size() == 0) chk("dropped_unexpected", 1, 0);
        else chk("dropped_edge", ecnt, xd.pop_front());
      end else if (xd.size() > 0 && xd[0] <= ecnt) begin
        chk("dropped_missing", 0, 1);
        void'(xd.pop_front());
      end
      chk("busy", busy, m_busy);
      chk("queue_full", queue_full, m_full);
    end
  end

  task automatic put(input logic [7:0] c);
    @(negedge clk);
    cv = 1'b1;
    code = c;
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      @(negedge clk);
      cv = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(m_idle && mq.size() == 0 && xr.size() == 0 &&
             xs.size() == 0 && xz.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("drain_timeout", 0, 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("reset_immediate",
           {rom_en, sample_strobe, busy, queue_full, dropped,
            audio_out}, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  logic [7:0] rc;

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    // Single kiss clip
    put(8'h83); quiet(1);
    wait_idle(400);
    // Non-emoji codes are ignored
    put(8'h41); quiet(1);
    put(8'h7F); put(8'h84); quiet(1);
    quiet(30);
    // Three clips back to back
    put(8'h80); put(8'h81); put(8'h82); quiet(1);
    wait_idle(800);
    // Overflow while playing, then push on a full popping FIFO
    put(8'h81); quiet(10);
    put(8'h80); put(8'h81); put(8'h82);
    put(8'h83); put(8'h80); quiet(1);
    n = 0;
    while (ecnt != m_g && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("clip_end_timeout", 0, 1);
    put(8'h83); quiet(1);
    wait_idle(2000);
    // Reset in mid-clip with two queued
    put(8'h81); put(8'h82); put(8'h83); quiet(1);
    quiet(25);
    pulse_reset();
    quiet(5);
    put(8'h82); quiet(1);
    wait_idle(400);
    // Random traffic
    repeat (40) begin
      if ($urandom_range(0, 3) == 0) rc = 8'($urandom);
      else rc = {6'b100000, 2'($urandom)};
      put(rc);
      quiet($urandom_range(1, 30));
    end
    wait_idle(6000);
    quiet(5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
